// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with registered one-hot grant and valid/ready handshake.
// Define ARB_STATS_EN to add the 16-bit accepted-grant counter port grant_count.
module rr_grant_arbiter #(
  parameter int N = 8,
  parameter int PW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic [N-1:0] grant,
  output logic         grant_valid
`ifdef ARB_STATS_EN
  ,output logic [15:0] grant_count
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [N-1:0] grant_q, grant_nx;
  logic [PW-1:0] ptr, ptr_nx, gidx, base, win, idx;
  logic found, xfer, load;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) if (grant_q[i]) gidx = PW'(i);
  end
  assign xfer = state == GRANT && grant_ready;
  assign load = state == IDLE || xfer;
  // After a transfer the scan starts just past the winner so it drops to lowest priority.
  assign base = xfer ? PW'(gidx + PW'(1)) : ptr;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'(base + PW'(k));
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_nx = load ? (found ? GRANT : IDLE) : state;
    grant_nx = load ? (found ? N'(1) << win : '0) : grant_q;
    ptr_nx = xfer ? base : ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_q <= '0;
      ptr <= '0;
    end else begin
      state <= state_nx;
      grant_q <= grant_nx;
      ptr <= ptr_nx;
    end
  end
  assign grant = grant_q;
  assign grant_valid = state == GRANT;
`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) grant_count <= '0;
    else if (xfer) grant_count <= grant_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: scoreboard bench for rr_grant_arbiter against a queue-fed reference model.
module tb_rr_grant_arbiter;
  localparam int N = 8;
  typedef struct {
    logic v;
    logic [N-1:0] g;
    logic [15:0] c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic grant_ready = 1'b0;
  logic [N-1:0] grant;
  logic grant_valid;
  logic [15:0] grant_count;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  logic m_valid = 1'b0;
  int m_idx = 0, m_ptr = 0;
  logic [15:0] m_cnt = '0;
  rr_grant_arbiter #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .grant_ready(grant_ready),
    .grant(grant),
    .grant_valid(grant_valid)
`ifdef ARB_STATS_EN
    ,.grant_count(grant_count)
`endif
  );
`ifndef ARB_STATS_EN
  assign grant_count = '0;
`endif
  always #5 clk = ~clk;
  // Drive one cycle of inputs and push what the arbiter must show after the next edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic rdy);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    grant_ready = rdy;
    if (r) begin
      m_valid = 1'b0;
      m_ptr = 0;
      m_cnt = '0;
    end else if (!m_valid || rdy) begin
      if (m_valid) begin
        m_cnt = m_cnt + 16'd1;
        m_ptr = (m_idx + 1) % N;
      end
      m_valid = rq != '0;
      if (m_valid)
        for (int k = N - 1; k >= 0; k--) if (rq[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
    end
    e.v = m_valid;
    e.g = m_valid ? N'(1) << m_idx : '0;
    e.c = m_cnt;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      checks++;
      if (grant_valid !== mon_e.v || grant !== mon_e.g) begin
        failures++;
        $display("FAIL grant t=%0t got valid=%b grant=%h want valid=%b grant=%h",
                 $time, grant_valid, grant, mon_e.v, mon_e.g);
      end
`ifdef ARB_STATS_EN
      checks++;
      if (grant_count !== mon_e.c) begin
        failures++;
        $display("FAIL grant_count t=%0t got %0d want %0d", $time, grant_count, mon_e.c);
      end
`endif
    end
  end
  initial begin
    repeat (3) step(1'b1, 8'hFF, 1'b1);
    repeat (10) step(1'b0, 8'hFF, 1'b1);
    repeat (5) step(1'b0, 8'h81, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h06, 1'b0);
    repeat (2) step(1'b0, 8'h06, 1'b0);
    step(1'b0, 8'h04, 1'b0);
    step(1'b0, 8'h04, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    repeat (2) step(1'b0, 8'h10, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b1);
    repeat (4) step(1'b0, 8'h01, 1'b1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, N'($urandom), 1'($urandom));
`ifdef ARB_STATS_EN
    step(1'b1, 8'hFF, 1'b1);
    repeat (70000) step(1'b0, 8'hFF, 1'b1);
    repeat (5) step(1'b0, 8'hFF, 1'b0);
`endif
    step(1'b0, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
